// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clk_div_bank clock-enable generator.
package clk_div_pkg;

  // Storage width of a queued ratio/phase; DIV_W must not exceed this.
  localparam int unsigned CfgW = 16;

  typedef enum logic [0:0] {
    StLockWait,
    StRun
  } clk_div_state_t;

  typedef struct packed {
    logic [2:0]      ch;
    logic [CfgW-1:0] div;
    logic [CfgW-1:0] phase;
  } clk_div_cfg_t;

  function automatic logic [CfgW-1:0] norm_div(input logic [CfgW-1:0] d);
    return (d == '0) ? CfgW'(1) : d;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: phase counter, registered enable/square outputs and
// glitch-free retiming of a queued ratio/phase on wrap or sync.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned DEF_DIV = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic             stop_i,
  input  logic             load_i,
  input  logic             sync_i,
  input  logic             upd_i,
  input  logic [DIV_W-1:0] upd_div_i,
  input  logic [DIV_W-1:0] upd_phase_i,
  output logic             take_o,
  output logic             ce_o,
  output logic             sq_o
);

  logic [DIV_W-1:0] div_q, phase_q, cnt_q;
  logic             ce_q, sq_q;
  logic             active, wrap;
  logic [DIV_W:0]   half;

  assign active = run_i & ~stop_i;
  assign wrap   = (cnt_q == div_q - DIV_W'(1));
  assign half   = ({1'b0, div_q} + (DIV_W + 1)'(1)) >> 1;

  // Lock loss blocks the update; in lock-wait it lands immediately.
  assign take_o = upd_i & (~run_i | (active & (sync_i | wrap)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q   <= DIV_W'(DEF_DIV);
      phase_q <= '0;
      cnt_q   <= '0;
      ce_q    <= 1'b0;
      sq_q    <= 1'b0;
    end else begin
      ce_q <= active & wrap & ~sync_i;
      sq_q <= active & ({1'b0, cnt_q} < half);
      if (take_o) begin
        div_q   <= upd_div_i;
        phase_q <= upd_phase_i;
        cnt_q   <= upd_phase_i;
      end else if (active) begin
        if (sync_i) begin
          cnt_q <= phase_q;
        end else if (wrap) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + DIV_W'(1);
        end
      end else if (load_i) begin
        cnt_q <= phase_q;
      end
    end
  end

  assign ce_o = ce_q;
  assign sq_o = sq_q;

endmodule

// File: rtl/clk_div_bank.sv
// PLL-lock sequencer plus a bank of programmable clock-enable dividers with a
// single-entry configuration slot.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned LOCK_CYC = 1024,
  parameter int unsigned DEF_DIV  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_lock,
  input  logic              sync_i,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] ce_o,
  output logic [NUM_CH-1:0] sq_o,
  output logic              locked_o,
  output logic              rst_o
);

  localparam int unsigned            LockCntW   = $clog2(LOCK_CYC + 1);
  localparam logic [LockCntW-1:0]    LockCntMax = LockCntW'(LOCK_CYC);

  clk_div_state_t      state_q;
  logic                lock_meta_q, lock_sync_q;
  logic [LockCntW-1:0] lock_cnt_q;
  logic                locked_q, rst_q;
  logic                run, stop, enter;

  clk_div_cfg_t        pend_q, cfg_new;
  logic                pend_valid_q;
  logic                cfg_in_range;
  logic [NUM_CH-1:0]   upd, take;
  logic                unused_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_sync_q <= lock_meta_q;
    end
  end

  assign run   = (state_q == StRun);
  assign stop  = run & ~lock_sync_q;
  assign enter = ~run & lock_sync_q & (lock_cnt_q == LockCntMax);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StLockWait;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      rst_q      <= 1'b1;
    end else begin
      // Saturates in RUN so any drop forces a full recount.
      if (!lock_sync_q) begin
        lock_cnt_q <= '0;
      end else if (lock_cnt_q != LockCntMax) begin
        lock_cnt_q <= lock_cnt_q + LockCntW'(1);
      end
      unique case (state_q)
        StLockWait: begin
          if (enter) begin
            state_q  <= StRun;
            locked_q <= 1'b1;
            rst_q    <= 1'b0;
          end
        end
        StRun: begin
          if (!lock_sync_q) begin
            state_q  <= StLockWait;
            locked_q <= 1'b0;
            rst_q    <= 1'b1;
          end
        end
        default: state_q <= StLockWait;
      endcase
    end
  end

  assign cfg_in_range = (32'(cfg_ch) < NUM_CH);

  always_comb begin
    cfg_new.ch    = cfg_ch;
    cfg_new.div   = norm_div(CfgW'(cfg_div));
    cfg_new.phase = (CfgW'(cfg_phase) >= cfg_new.div) ? '0 : CfgW'(cfg_phase);
  end

  // Out-of-range channels are accepted and dropped without occupying the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
    end else if (|take) begin
      pend_valid_q <= 1'b0;
    end else if (cfg_valid && !pend_valid_q && cfg_in_range) begin
      pend_valid_q <= 1'b1;
      pend_q       <= cfg_new;
    end
  end

  assign unused_pend = ^pend_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    assign upd[i] = pend_valid_q && (pend_q.ch == 3'(i));

    clk_div_chan #(
      .DIV_W  (DIV_W),
      .DEF_DIV(DEF_DIV)
    ) u_chan (
      .clk_i      (clk),
      .rst_i      (rst),
      .run_i      (run),
      .stop_i     (stop),
      .load_i     (enter),
      .sync_i     (sync_i),
      .upd_i      (upd[i]),
      .upd_div_i  (DIV_W'(pend_q.div)),
      .upd_phase_i(DIV_W'(pend_q.phase)),
      .take_o     (take[i]),
      .ce_o       (ce_o[i]),
      .sq_o       (sq_o[i])
    );
  end

  assign cfg_ready = ~pend_valid_q;
  assign locked_o  = locked_q;
  assign rst_o     = rst_q;

endmodule
